// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit.
package branch_pkg;

   // Resolver sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_RECOVER = 2'd2
   } brs_state_e;

   // Fall-through distance for a not-taken branch (word-aligned fetch)
   localparam int PC_INC = 4;

   // Queue entry layout: {pc[PC_W], taken[1], target[PC_W]}
   localparam int ENT_TAKEN_W = 1;

   function automatic int entry_w(input int pc_w);
      return 2 * pc_w + ENT_TAKEN_W;
   endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-flight prediction queue: synchronous FIFO with flush-clear.
// Read data is the current head, available combinationally.
module pred_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; clear discards everything queued this cycle too
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // Pointer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; when full with a same-cycle pop the head slot is reused
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch predictions, checks them in order
// against EX outcomes, updates the branch history table and raises
// flush/redirect on a mispredict.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | normal operation, pushes and resolves accepted
// ST_FLUSH   | one-cycle flush pulse, redirect_pc valid, queue empty
// ST_RECOVER | RECOVER_CYC refill cycles, fetch stalled
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int LOWER       = 5,
   parameter int PC_W        = 32,
   parameter int DEPTH       = 4,
   parameter int RECOVER_CYC = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pred_valid,
   input  logic [PC_W-1:0]  pred_pc,
   input  logic             pred_taken,
   input  logic [PC_W-1:0]  pred_target,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic             res_jump,
   input  logic [PC_W-1:0]  res_target,
   output logic             bht_en,
   output logic [LOWER-1:0] bht_write_addr,
   output logic             bht_was_taken,
   output logic             bht_jumped,
   output logic             stall_fetch,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt,
   output logic             err_underflow
);

   localparam int EW  = entry_w(PC_W);
   localparam int RCW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

   brs_state_e       state_q, state_d;
   logic [RCW-1:0]   rec_cnt_q, rec_cnt_d;

   logic [EW-1:0]    head;
   logic [PC_W-1:0]  head_pc, head_target;
   logic             head_taken;
   logic             q_full, q_empty;
   logic             is_idle, resolve, actual, mispredict, push, q_clear;

   logic             bht_en_q;
   logic [LOWER-1:0] bht_addr_q;
   logic             bht_taken_q, bht_jumped_q;
   logic [PC_W-1:0]  redirect_q, redirect_d;
   logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;
   logic             err_q;

   assign head_pc     = head[EW-1 -: PC_W];
   assign head_taken  = head[PC_W];
   assign head_target = head[PC_W-1:0];

   assign is_idle     = (state_q == ST_IDLE);
   assign stall_fetch = q_full || !is_idle;
   assign resolve     = res_valid && is_idle && !q_empty;
   assign actual      = res_taken || res_jump;
   assign mispredict  = (head_taken != actual) || (actual && (head_target != res_target));

   // A same-cycle pop frees the slot even when full; pushes alongside a
   // mispredict are wrong-path and dropped.
   assign push    = pred_valid && is_idle && (!q_full || resolve) && !(resolve && mispredict);
   assign q_clear = resolve && mispredict;

   assign redirect_d = actual ? res_target : (head_pc + PC_W'(PC_INC));

   pred_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_pred_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (q_clear),
      .push  (push),
      .pop   (resolve),
      .wdata ({pred_pc, pred_taken, pred_target}),
      .rdata (head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Next-state: flush for one cycle, then count down the refill window
   always_comb begin
      state_d   = state_q;
      rec_cnt_d = rec_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (resolve && mispredict) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            state_d   = ST_RECOVER;
            rec_cnt_d = RCW'(RECOVER_CYC - 1);
         end
         ST_RECOVER: begin
            if (rec_cnt_q == '0) state_d = ST_IDLE;
            else                 rec_cnt_d = rec_cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rec_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rec_cnt_q <= rec_cnt_d;
      end
   end

   // Table update, redirect, statistics and error flag, one cycle after resolve
   always_ff @(posedge clk) begin
      if (rst) begin
         bht_en_q         <= 1'b0;
         bht_addr_q       <= '0;
         bht_taken_q      <= 1'b0;
         bht_jumped_q     <= 1'b0;
         redirect_q       <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
         err_q            <= 1'b0;
      end else begin
         bht_en_q   <= resolve;
         redirect_q <= q_clear ? redirect_d : '0;
         if (resolve) begin
            bht_addr_q   <= head_pc[LOWER+1:2];
            bht_taken_q  <= res_taken;
            bht_jumped_q <= res_jump;
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (mispredict && (mispredict_cnt_q != '1))
               mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
         end
         if (res_valid && !resolve) err_q <= 1'b1;
      end
   end

   assign bht_en         = bht_en_q;
   assign bht_write_addr = bht_addr_q;
   assign bht_was_taken  = bht_taken_q;
   assign bht_jumped     = bht_jumped_q;
   assign flush          = (state_q == ST_FLUSH);
   assign redirect_pc    = redirect_q;
   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;
   assign err_underflow  = err_q;

endmodule
